// File: rtl/uart_rx_framed.sv
// uart_rx_framed: UART receiver with 5..9 data bits, optional parity, 1/2 stop
// bits, start-glitch rejection, per-word error flags and a show-ahead FIFO.
// Ports: i_clock, i_reset (sync, high), i_rx serial line;
// o_data_valid/i_data_ready handshake for o_data, o_parity_error and
// o_framing_error; o_overrun drop pulse; o_busy receiver active.
module uart_rx_framed #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_rx,
  output logic                 o_data_valid,
  input  logic                 i_data_ready,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_parity_error,
  output logic                 o_framing_error,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int WW = DATA_BITS + 2;
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0] DLAST = 4'(DATA_BITS - 1);
  localparam logic SLAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           sync_q, sync_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 pe_q, pe_d;
  logic                 fe_q, fe_d;
  logic                 push_q, push_d;
  logic [WW-1:0]        word_q, word_d;
  logic [PW-1:0]        wptr_q, wptr_d;
  logic [PW-1:0]        rptr_q, rptr_d;
  logic                 ovr_q, ovr_d;
  logic [WW-1:0]        mem_q [FIFO_DEPTH];

  logic          rx_s, tick, par_exp;
  logic          empty, full, pop, wr_en;
  logic [WW-1:0] head;

  assign rx_s = sync_q[1];
  assign tick = (cnt_q == LAST);
  assign par_exp = (PARITY == 1) ? ~(^shift_q) : ^shift_q;

  always_comb begin
    sync_d  = {sync_q[0], i_rx};
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    push_d  = 1'b0;
    word_d  = word_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            bit_d   = '0;
            stop_d  = 1'b0;
            pe_d    = 1'b0;
            fe_d    = 1'b0;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 4'd1;
          if (bit_q == DLAST)
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
        end
      end
      S_PAR: begin
        if (tick) begin
          cnt_d   = '0;
          pe_d    = rx_s ^ par_exp;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          cnt_d  = '0;
          fe_d   = fe_q | ~rx_s;
          stop_d = stop_q + 1'b1;
          if (stop_q == SLAST) begin
            push_d = 1'b1;
            word_d = {fe_d, pe_q, shift_q};
            // A good stop bit re-arms at mid-bit so the next start edge is seen.
            state_d = fe_d ? S_BRK : S_IDLE;
          end
        end
      end
      S_BRK: begin
        cnt_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    empty  = (wptr_q == rptr_q);
    full   = ((wptr_q - rptr_q) == PW'(FIFO_DEPTH));
    pop    = ~empty & i_data_ready;
    wr_en  = push_q & (~full | pop);
    ovr_d  = push_q & full & ~pop;
    wptr_d = wptr_q + PW'(wr_en);
    rptr_d = rptr_q + PW'(pop);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      push_q  <= 1'b0;
      word_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
      push_q  <= push_d;
      word_q  <= word_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      ovr_q   <= ovr_d;
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge i_clock) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= word_q;
  end

  assign head            = mem_q[rptr_q[AW-1:0]];
  assign o_data_valid    = ~empty;
  assign o_data          = empty ? '0 : head[DATA_BITS-1:0];
  assign o_parity_error  = ~empty & head[DATA_BITS];
  assign o_framing_error = ~empty & head[DATA_BITS+1];
  assign o_overrun       = ovr_q;
  assign o_busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_framed.sv
// tb_uart_rx_framed: directed bench for uart_rx_framed
// (8N1, 8E1 and 9O2 instances sharing one clock).
module tb_uart_rx_framed;

  localparam int C    = 16;
  localparam int HALF = (C - 1) / 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;
  logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
  logic rdy0 = 1'b1, rdy1 = 1'b1, rdy2 = 1'b1;
  logic v0, v1, v2, pe0, pe1, pe2, fe0, fe1, fe2;
  logic ovr0, ovr1, ovr2, bz0, bz1, bz2;
  logic [7:0] d0, d1;
  logic [8:0] d2;

  uart_rx_framed #(.CLKS_PER_BIT(C)) u_8n1 (
    .i_clock(clk), .i_reset(rst0), .i_rx(rx0),
    .o_data_valid(v0), .i_data_ready(rdy0), .o_data(d0),
    .o_parity_error(pe0), .o_framing_error(fe0),
    .o_overrun(ovr0), .o_busy(bz0)
  );

  uart_rx_framed #(.CLKS_PER_BIT(C), .PARITY(2)) u_8e1 (
    .i_clock(clk), .i_reset(rst1), .i_rx(rx1),
    .o_data_valid(v1), .i_data_ready(rdy1), .o_data(d1),
    .o_parity_error(pe1), .o_framing_error(fe1),
    .o_overrun(ovr1), .o_busy(bz1)
  );

  uart_rx_framed #(
    .CLKS_PER_BIT(C), .DATA_BITS(9), .PARITY(1), .STOP_BITS(2)
  ) u_9o2 (
    .i_clock(clk), .i_reset(rst2), .i_rx(rx2),
    .o_data_valid(v2), .i_data_ready(rdy2), .o_data(d2),
    .o_parity_error(pe2), .o_framing_error(fe2),
    .o_overrun(ovr2), .o_busy(bz2)
  );

  int n_tests = 0;
  int n_fail = 0;
  int ovr_cnt0 = 0;
  int lat = 0;
  logic saw = 1'b0;
  logic [10:0] q0[$], q1[$], q2[$];

  // Words are logged as {fe, pe, data} when the consumer takes them.
  always @(negedge clk) begin
    if (v0 && rdy0) q0.push_back({fe0, pe0, 1'b0, d0});
    if (v1 && rdy1) q1.push_back({fe1, pe1, 1'b0, d1});
    if (v2 && rdy2) q2.push_back({fe2, pe2, d2});
    if (ovr0) ovr_cnt0++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int qsize(input int s);
    case (s)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [31:0] qget(input int s, input int i);
    logic [10:0] w;
    w = 11'h7FF;
    case (s)
      0: if (i < q0.size()) w = q0[i];
      1: if (i < q1.size()) w = q1[i];
      default: if (i < q2.size()) w = q2[i];
    endcase
    return 32'(w);
  endfunction

  task automatic set_rx(input int s, input logic v);
    case (s)
      0: rx0 = v;
      1: rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  task automatic bit_time(input int s, input logic v);
    set_rx(s, v);
    repeat (C) @(negedge clk);
  endtask

  // Call at a negedge; ends at a negedge with the last stop level held.
  task automatic send(input int s, input logic [8:0] d, input int nb,
                      input int par, input logic pb,
                      input int ns, input logic sb);
    bit_time(s, 1'b0);
    for (int i = 0; i < nb; i++) bit_time(s, d[i]);
    if (par != 0) bit_time(s, pb);
    for (int i = 0; i < ns; i++) bit_time(s, sb);
  endtask

  task automatic wait_q(input int s, input int n);
    int k;
    k = 0;
    while (qsize(s) < n && k < 4000) begin
      @(negedge clk);
      k++;
    end
    repeat (2 * C) @(negedge clk);
  endtask

  localparam int LAT8N1 = 4 + HALF + C * 9;

  initial begin
    repeat (3) @(negedge clk);
    rst0 = 1'b0;
    rst1 = 1'b0;
    rst2 = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(v0), 32'd0);
    check("rst_data", 32'(d0), 32'd0);
    check("rst_pe", 32'(pe0), 32'd0);
    check("rst_fe", 32'(fe0), 32'd0);
    check("rst_ovr", 32'(ovr0), 32'd0);
    check("rst_busy", 32'(bz0), 32'd0);

    // back-to-back 8N1 with latency of the first word
    q0.delete();
    ovr_cnt0 = 0;
    fork
      begin
        send(0, 9'h0AA, 8, 0, 1'b0, 1, 1'b1);
        send(0, 9'h0BB, 8, 0, 1'b0, 1, 1'b1);
      end
      begin
        @(posedge clk);
        lat = 0;
        while (!v0 && lat < 1000) begin
          @(posedge clk);
          #1;
          lat++;
        end
      end
    join
    check("lat_8n1", (lat >= LAT8N1 - 1 && lat <= LAT8N1 + 1) ?
          32'(LAT8N1) : 32'(lat), 32'(LAT8N1));
    wait_q(0, 2);
    check("b2b_cnt", 32'(q0.size()), 32'd2);
    check("b2b_w0", qget(0, 0), 32'h0AA);
    check("b2b_w1", qget(0, 1), 32'h0BB);
    check("b2b_ovr", 32'(ovr_cnt0), 32'd0);

    // even parity: correct then wrong parity bit
    q1.delete();
    send(1, 9'h055, 8, 2, 1'b0, 1, 1'b1);
    send(1, 9'h055, 8, 2, 1'b1, 1, 1'b1);
    wait_q(1, 2);
    check("even_cnt", 32'(q1.size()), 32'd2);
    check("even_ok", qget(1, 0), 32'h055);
    check("even_bad", qget(1, 1), 32'h255);

    // framing error followed by a break, then a clean frame
    q0.delete();
    send(0, 9'h03C, 8, 0, 1'b0, 1, 1'b0);
    repeat (3 * C) @(negedge clk);
    check("brk_busy", 32'(bz0), 32'd1);
    rx0 = 1'b1;
    repeat (2 * C) @(negedge clk);
    send(0, 9'h081, 8, 0, 1'b0, 1, 1'b1);
    wait_q(0, 2);
    check("brk_cnt", 32'(q0.size()), 32'd2);
    check("brk_w0", qget(0, 0), 32'h43C);
    check("brk_w1", qget(0, 1), 32'h081);

    // four-cycle start glitch
    q0.delete();
    rx0 = 1'b0;
    saw = 1'b0;
    for (int k = 0; k <= HALF + 4; k++) begin
      @(posedge clk);
      #1;
      if (bz0) saw = 1'b1;
      if (k == 3) rx0 = 1'b1;
    end
    check("glitch_busy_seen", 32'(saw), 32'd1);
    check("glitch_busy_clr", 32'(bz0), 32'd0);
    repeat (2 * C) @(negedge clk);
    check("glitch_no_word", 32'(q0.size()) + 32'(v0), 32'd0);

    // overrun with the consumer stalled
    q0.delete();
    ovr_cnt0 = 0;
    rdy0 = 1'b0;
    for (int i = 1; i <= 5; i++) send(0, 9'(i), 8, 0, 1'b0, 1, 1'b1);
    repeat (2 * C) @(negedge clk);
    check("ovr_pulses", 32'(ovr_cnt0), 32'd1);
    check("ovr_head_valid", 32'(v0), 32'd1);
    check("ovr_head_data", 32'(d0), 32'h01);
    @(posedge clk);
    #1;
    rdy0 = 1'b1;
    repeat (8) @(negedge clk);
    check("ovr_cnt", 32'(q0.size()), 32'd4);
    for (int i = 0; i < 4; i++) check("ovr_word", qget(0, i), 32'(i + 1));
    check("ovr_empty", 32'(v0), 32'd0);

    // 9O2: reset during data bit 4, then a clean frame
    q2.delete();
    fork
      send(2, 9'h1F1, 9, 1, 1'b1, 2, 1'b1);
      begin
        repeat (5 * C + C / 2) @(negedge clk);
        @(posedge clk);
        #1;
        rst2 = 1'b1;
        @(posedge clk);
        #1;
        rst2 = 1'b0;
        check("rst_mid_busy", 32'(bz2), 32'd0);
      end
    join
    repeat (3 * C) @(negedge clk);
    check("rst_mid_none", 32'(q2.size()) + 32'(v2), 32'd0);
    send(2, 9'h1C3, 9, 1, 1'b0, 2, 1'b1);
    wait_q(2, 1);
    check("w9_cnt", 32'(q2.size()), 32'd1);
    check("w9_word", qget(2, 0), 32'h1C3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
